// File: rtl/lsu_pkg.sv
// Shared types and byte-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WRITE, DONE} lsu_state_t;

  localparam int unsigned BYTE_W = 8;

  // Little-endian lanes: lane 0 is bits [7:0], lane 3 is bits [31:24].
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    logic [31:0] res;
    res = '0;
    res[BYTE_W-1:0] = word[{lane, 3'b000} +: BYTE_W];
    return res;
  endfunction

  function automatic logic [31:0] lane_insert(input logic [31:0]       word,
                                              input logic [BYTE_W-1:0] data,
                                              input logic [1:0]        lane);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: BYTE_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane view of a memory word: zero-extended lane read and lane replace.
module byte_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic [1:0]        lane_i,
  output logic [31:0]       extract_o,
  output logic [31:0]       merged_o
);

  assign extract_o = lane_extract(word_i, lane_i);
  assign merged_o  = lane_insert(word_i, byte_i, lane_i);

endmodule

// File: rtl/load_store_unit.sv
// Sequences one load/store at a time onto a word-wide DataMemory port, adding byte
// loads, read-modify-write byte stores and alignment/range checking.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t        state_q;
  logic [1:0]        lane_q;
  logic [BYTE_W-1:0] wbyte_q;
  logic              write_q;
  logic              byte_q;

  logic              req_err;
  logic [31:0]       lane_word;
  logic [31:0]       merged_word;

  // Out-of-range words are rejected rather than aliased onto the memory.
  assign req_err = (!req_byte && (req_address[1:0] != 2'b00)) ||
                   ({2'b00, req_address[31:2]} >= MEM_WORDS);

  assign req_ready = (state_q == IDLE);

  byte_lane_merge u_merge (
    .word_i    (mem_read_data),
    .byte_i    (wbyte_q),
    .lane_i    (lane_q),
    .extract_o (lane_word),
    .merged_o  (merged_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      lane_q           <= '0;
      wbyte_q          <= '0;
      write_q          <= 1'b0;
      byte_q           <= 1'b0;
      resp_valid       <= 1'b0;
      resp_read_data   <= '0;
      resp_error       <= 1'b0;
      mem_address      <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= '0;
    end else begin
      resp_valid       <= 1'b0;
      resp_read_data   <= '0;
      resp_error       <= 1'b0;
      mem_write_enable <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            lane_q  <= req_address[1:0];
            wbyte_q <= req_write_data[BYTE_W-1:0];
            write_q <= req_write;
            byte_q  <= req_byte;
            if (req_err) begin
              state_q    <= DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
            end else begin
              state_q     <= ACCESS;
              mem_address <= {req_address[31:2], 2'b00};
              if (req_write && !req_byte) begin
                mem_write_enable <= 1'b1;
                mem_write_data   <= req_write_data;
              end
            end
          end
        end
        ACCESS: begin
          if (write_q && byte_q) begin
            // The read word is merged now and written back next cycle.
            state_q          <= RMW_WRITE;
            mem_write_enable <= 1'b1;
            mem_write_data   <= merged_word;
          end else begin
            state_q    <= DONE;
            resp_valid <= 1'b1;
            if (!write_q) begin
              resp_read_data <= byte_q ? lane_word : mem_read_data;
            end
          end
        end
        RMW_WRITE: begin
          state_q    <= DONE;
          resp_valid <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
